// File: rtl/zsdram_pkg.sv
// rtl/zsdram_pkg.sv - shared SDRAM command codes, request codes, address fields and sequencer states
//
// Contents:
//   CMD_*      : {cs_n, ras_n, cas_n, we_n} command encodings
//   RW_*       : rw_req codes from the read/write arbiter
//   *_MSB/LSB  : field positions inside rw_addr = {bank, row, col}
//   seq_state_t: sequencer state enum
//   addr_*()   : field extraction helpers, max_int() for sizing
package zsdram_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_MRS       = 4'b0000;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam int BA_MSB  = 23;
  localparam int BA_LSB  = 22;
  localparam int ROW_MSB = 21;
  localparam int ROW_LSB = 9;
  localparam int COL_MSB = 8;
  localparam int COL_LSB = 0;

  // A10 selects auto-precharge on READ/WRITE and all-bank on PRECHARGE
  localparam int A10_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REF,
    ST_ACT,
    ST_WR,
    ST_RD,
    ST_PRE,
    ST_DONE,
    ST_REL
  } seq_state_t;

  function automatic logic [1:0] addr_bank(input logic [23:0] a);
    return a[BA_MSB:BA_LSB];
  endfunction

  function automatic logic [12:0] addr_row(input logic [23:0] a);
    return a[ROW_MSB:ROW_LSB];
  endfunction

  function automatic logic [8:0] addr_col(input logic [23:0] a);
    return a[COL_MSB:COL_LSB];
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/zsdram_ref_timer.sv
// rtl/zsdram_ref_timer.sv - refresh interval counter and pending-refresh flag
//
// Ports:
//   clk         in  : clock
//   rst         in  : synchronous active-high reset
//   init_done   in  : counter runs only once SDRAM init is complete
//   ref_clr     in  : sequencer has issued AUTO REFRESH, drop the request
//   ref_pending out : a refresh is owed
import zsdram_pkg::*;

module zsdram_ref_timer #(
  parameter int REF_CYCLES = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic init_done,
  input  logic ref_clr,
  output logic ref_pending
);

  localparam int CW = $clog2(REF_CYCLES);

  logic [CW-1:0] ref_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else if (!init_done) begin
      ref_cnt <= '0;
    end else if (ref_cnt == CW'(REF_CYCLES - 1)) begin
      // A wrap always (re)asserts the flag; one flag means at most one owed refresh.
      // Set beats a same-cycle clear so a fresh interval is never lost.
      ref_cnt     <= '0;
      ref_pending <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
      if (ref_clr) begin
        ref_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/zsdram_rw_seq.sv
// rtl/zsdram_rw_seq.sv - SDRAM read/write command sequencer with periodic auto refresh
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   init_done                : SDRAM power-up sequence finished
//   rw_req[1:0], rw_addr[23:0]: request (01 rd, 10 wr) and {bank,row,col}
//   rd_done, wr_done         : one-cycle completion pulses
//   wr_data, wr_data_req     : show-ahead write FIFO word and its pop strobe
//   rd_data, rd_data_vld     : captured read words
//   sdr_cmd, sdr_ba, sdr_addr: registered SDRAM command/address pins
//   sdr_dq_out, sdr_dq_oe    : registered write data and output enable
//   sdr_dq_in                : DQ input
import zsdram_pkg::*;

module zsdram_rw_seq #(
  parameter int T_RCD      = 2,
  parameter int T_RP       = 2,
  parameter int T_WR       = 2,
  parameter int T_RFC      = 7,
  parameter int CL         = 3,
  parameter int BL         = 8,
  parameter int REF_CYCLES = 780
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic [1:0]  rw_req,
  input  logic [23:0] rw_addr,
  output logic        rd_done,
  output logic        wr_done,
  input  logic [15:0] wr_data,
  output logic        wr_data_req,
  output logic [15:0] rd_data,
  output logic        rd_data_vld,
  output logic [3:0]  sdr_cmd,
  output logic [1:0]  sdr_ba,
  output logic [12:0] sdr_addr,
  output logic [15:0] sdr_dq_out,
  output logic        sdr_dq_oe,
  input  logic [15:0] sdr_dq_in
);

  // One shared wait counter; the read path counts through CAS latency plus the burst.
  localparam int TMR_MAX = max_int(max_int(T_RFC, BL + T_WR), CL + BL);
  localparam int TW      = $clog2(TMR_MAX + 1);

  seq_state_t    state;
  logic [TW-1:0] tmr;
  logic          is_wr;
  logic [1:0]    lat_ba;
  logic [8:0]    lat_col;
  logic          ref_clr;
  logic          ref_pending;

  zsdram_ref_timer #(
    .REF_CYCLES(REF_CYCLES)
  ) u_ref_timer (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_done),
    .ref_clr    (ref_clr),
    .ref_pending(ref_pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      is_wr       <= 1'b0;
      lat_ba      <= '0;
      lat_col     <= '0;
      ref_clr     <= 1'b0;
      sdr_cmd     <= CMD_NOP;
      sdr_ba      <= '0;
      sdr_addr    <= '0;
      sdr_dq_out  <= '0;
      sdr_dq_oe   <= 1'b0;
      wr_data_req <= 1'b0;
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
      rd_done     <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      // Commands and strobes are single-cycle unless a state re-asserts them.
      sdr_cmd     <= CMD_NOP;
      rd_data_vld <= 1'b0;
      rd_done     <= 1'b0;
      wr_done     <= 1'b0;
      ref_clr     <= 1'b0;
      tmr         <= tmr + 1'b1;

      // A word popped this cycle lands on the pins next cycle, so the output
      // enable is simply the pop strobe delayed by one.
      sdr_dq_oe <= wr_data_req;
      if (wr_data_req) begin
        sdr_dq_out <= wr_data;
      end

      case (state)
        ST_IDLE: begin
          tmr <= '0;
          if (init_done) begin
            if (ref_pending) begin
              sdr_cmd <= CMD_AREF;
              ref_clr <= 1'b1;
              state   <= ST_REF;
            end else if (rw_req == RW_READ || rw_req == RW_WRITE) begin
              is_wr    <= (rw_req == RW_WRITE);
              lat_ba   <= addr_bank(rw_addr);
              lat_col  <= addr_col(rw_addr);
              sdr_cmd  <= CMD_ACTIVE;
              sdr_ba   <= addr_bank(rw_addr);
              sdr_addr <= addr_row(rw_addr);
              state    <= ST_ACT;
            end
          end
        end

        ST_REF: begin
          if (tmr == TW'(T_RFC - 1)) begin
            state <= ST_IDLE;
          end
        end

        ST_ACT: begin
          // The FIFO pop leads the WRITE command by one cycle (needs T_RCD >= 2).
          if (is_wr && tmr == TW'(T_RCD - 2)) begin
            wr_data_req <= 1'b1;
          end
          if (tmr == TW'(T_RCD - 1)) begin
            tmr      <= '0;
            sdr_cmd  <= is_wr ? CMD_WRITE : CMD_READ;
            sdr_ba   <= lat_ba;
            sdr_addr <= {4'b0000, lat_col};
            state    <= is_wr ? ST_WR : ST_RD;
          end
        end

        ST_WR: begin
          if (tmr == TW'(BL - 2)) begin
            wr_data_req <= 1'b0;
          end
          if (tmr == TW'(BL + T_WR - 2)) begin
            tmr      <= '0;
            sdr_cmd  <= CMD_PRECHARGE;
            sdr_addr <= 13'(1 << A10_BIT);
            state    <= ST_PRE;
          end
        end

        ST_RD: begin
          if (tmr >= TW'(CL) && tmr <= TW'(CL + BL - 1)) begin
            rd_data     <= sdr_dq_in;
            rd_data_vld <= 1'b1;
          end
          // Precharge goes out with the last captured word; the burst is already on the bus.
          if (tmr == TW'(CL + BL - 1)) begin
            tmr      <= '0;
            sdr_cmd  <= CMD_PRECHARGE;
            sdr_addr <= 13'(1 << A10_BIT);
            state    <= ST_PRE;
          end
        end

        ST_PRE: begin
          if (tmr == TW'(T_RP - 1)) begin
            wr_done <= is_wr;
            rd_done <= !is_wr;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          state <= ST_REL;
        end

        ST_REL: begin
          // Wait for the arbiter to drop the request so it is not taken twice.
          if (rw_req == RW_NONE) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
